// File: rtl/axi4_wr_chk.sv
// Passive AXI4 write-path checker: pairs AW bursts with W bursts, checks beat counts and B IDs.
// Optional B-response timeout is built only when AXI4_WCHK_TMO_EN is defined.
module axi4_wr_chk #(
    parameter int ID_W    = 4,
    parameter int DEPTH   = 8,
    parameter int TMO_CYC = 1024
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic                    awvalid,
    input  logic                    awready,
    input  logic [ID_W-1:0]         awid,
    input  logic [7:0]              awlen,
    input  logic                    wvalid,
    input  logic                    wready,
    input  logic                    wlast,
    input  logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_W-1:0]         bid,
    input  logic                    err_clr,
    output logic                    err_wlen,
    output logic                    err_b_orphan,
    output logic                    err_ovf,
    output logic                    err_tmo,
    output logic [$clog2(DEPTH):0]  wr_outst
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int NID = 1 << ID_W;

    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [8:0]    BEAT_SAT = 9'd256;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [7:0]      len;
    } aw_ent_t;

    logic aw_hs, w_hs, b_hs;

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign b_hs  = bvalid & bready;

    aw_ent_t       aw_mem [DEPTH];
    logic [PW-1:0] aw_rd_q, aw_wr_q;
    logic [CW-1:0] aw_num_q;

    logic [8:0]    w_mem [DEPTH];
    logic [PW-1:0] w_rd_q, w_wr_q;
    logic [CW-1:0] w_num_q;

    logic [8:0]    beat_q;
    logic [CW-1:0] cnt_q [NID];
    logic [CW-1:0] outst_q;
    logic          err_wlen_q, err_orph_q, err_ovf_q;

    aw_ent_t       aw_head;
    logic [8:0]    w_head;
    logic          pair, wlen_bad;
    logic          aw_push, aw_drop, w_push, w_drop;
    logic          same_id, inc_do, dec_do, inc_ovf, orphan, inc_ok, dec_ok;

    assign aw_head = aw_mem[aw_rd_q];
    assign w_head  = w_mem[w_rd_q];

    always_comb begin
        // NOTE: every signal gets a default first so no branch can leave it unassigned and infer a latch.
        pair     = 1'b0;
        wlen_bad = 1'b0;
        aw_push  = 1'b0;
        aw_drop  = 1'b0;
        w_push   = 1'b0;
        w_drop   = 1'b0;
        same_id  = 1'b0;
        inc_do   = 1'b0;
        dec_do   = 1'b0;
        inc_ovf  = 1'b0;
        orphan   = 1'b0;
        inc_ok   = 1'b0;
        dec_ok   = 1'b0;

        pair     = (aw_num_q != '0) && (w_num_q != '0);
        wlen_bad = pair && (w_head != ({1'b0, aw_head.len} + 9'd1));

        // A full queue still accepts a push when its head pops in the same cycle.
        if (aw_hs) begin
            if ((aw_num_q != FULL) || pair) aw_push = 1'b1;
            else                            aw_drop = 1'b1;
        end
        if (w_hs && wlast) begin
            if ((w_num_q != FULL) || pair) w_push = 1'b1;
            else                           w_drop = 1'b1;
        end

        // Pairing increment and B decrement on the same ID cancel out.
        same_id = pair && b_hs && (bid == aw_head.id);
        inc_do  = pair && !same_id;
        dec_do  = b_hs && !same_id;
        inc_ovf = inc_do && (cnt_q[aw_head.id] == FULL);
        orphan  = dec_do && (cnt_q[bid] == '0);
        inc_ok  = inc_do && !inc_ovf;
        dec_ok  = dec_do && !orphan;
    end

    // NOTE: queue storage has no reset; validity is carried by the reset pointers and counts alone.
    always_ff @(posedge aclk) begin
        if (aw_push) aw_mem[aw_wr_q] <= '{id: awid, len: awlen};
        if (w_push)  w_mem[w_wr_q]   <= beat_q + 9'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            aw_rd_q  <= '0;
            aw_wr_q  <= '0;
            aw_num_q <= '0;
            w_rd_q   <= '0;
            w_wr_q   <= '0;
            w_num_q  <= '0;
        end else begin
            if (aw_push) aw_wr_q <= aw_wr_q + PTR_ONE;
            if (w_push)  w_wr_q  <= w_wr_q + PTR_ONE;
            if (pair) begin
                aw_rd_q <= aw_rd_q + PTR_ONE;
                w_rd_q  <= w_rd_q + PTR_ONE;
            end
            aw_num_q <= aw_num_q + CW'(aw_push) - CW'(pair);
            w_num_q  <= w_num_q + CW'(w_push) - CW'(pair);
        end
    end

    // Beat counter stops at 256 so an over-long burst still pushes 257 and fails the length check.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            beat_q <= '0;
        end else if (w_hs) begin
            if (wlast)                 beat_q <= '0;
            else if (beat_q != BEAT_SAT) beat_q <= beat_q + 9'd1;
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < NID; i++) cnt_q[i] <= '0;
        end else begin
            if (inc_ok) cnt_q[aw_head.id] <= cnt_q[aw_head.id] + CNT_ONE;
            if (dec_ok) cnt_q[bid]        <= cnt_q[bid] - CNT_ONE;
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            outst_q <= '0;
        end else begin
            case ({inc_ok, dec_ok})
                2'b10:   outst_q <= outst_q + CNT_ONE;
                2'b01:   outst_q <= outst_q - CNT_ONE;
                default: outst_q <= outst_q;
            endcase
        end
    end

    // A new error in the same cycle as err_clr keeps its flag set.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            err_wlen_q <= 1'b0;
            err_orph_q <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            err_wlen_q <= wlen_bad | (err_wlen_q & ~err_clr);
            err_orph_q <= orphan | (err_orph_q & ~err_clr);
            err_ovf_q  <= aw_drop | w_drop | inc_ovf | (err_ovf_q & ~err_clr);
        end
    end

`ifdef AXI4_WCHK_TMO_EN
    localparam int            TW      = $clog2(TMO_CYC + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TMO_CYC);

    logic [TW-1:0] tmr_q, tmr_d;
    logic          err_tmo_q;

    always_comb begin
        tmr_d = tmr_q;
        if (b_hs || (outst_q == '0)) tmr_d = '0;
        else if (tmr_q != TMO_MAX)   tmr_d = tmr_q + TW'(1);
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            tmr_q     <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            tmr_q     <= tmr_d;
            err_tmo_q <= (tmr_d == TMO_MAX) | (err_tmo_q & ~err_clr);
        end
    end

    assign err_tmo = err_tmo_q;
`else
    // Constant 0; TMO_CYC only matters when the timer is built.
    assign err_tmo = 1'b0 & (TMO_CYC != 0);
`endif

    assign err_wlen     = err_wlen_q;
    assign err_b_orphan = err_orph_q;
    assign err_ovf      = err_ovf_q;
    assign wr_outst     = outst_q;

endmodule

// File: tb/tb_axi4_wr_chk.sv
// Bench for axi4_wr_chk: directed scenarios plus random traffic against a queue-based reference model.
module tb_axi4_wr_chk;

    localparam int ID_W    = 4;
    localparam int DEPTH   = 8;
    localparam int TMO_CYC = 16;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic            aclk = 1'b0;
    logic            areset_n = 1'b0;
    logic            awvalid = 1'b0, awready = 1'b0, wvalid = 1'b0, wready = 1'b0, wlast = 1'b0;
    logic            bvalid = 1'b0, bready = 1'b0, err_clr = 1'b0;
    logic [ID_W-1:0] awid = '0, bid = '0;
    logic [7:0]      awlen = '0;
    logic            err_wlen, err_b_orphan, err_ovf, err_tmo;
    logic [CW-1:0]   wr_outst;
    logic [CW+3:0]   obs;

    axi4_wr_chk #(.ID_W(ID_W), .DEPTH(DEPTH), .TMO_CYC(TMO_CYC)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid),
        .err_clr(err_clr),
        .err_wlen(err_wlen), .err_b_orphan(err_b_orphan), .err_ovf(err_ovf), .err_tmo(err_tmo),
        .wr_outst(wr_outst)
    );

    always #5 aclk = ~aclk;

    assign obs = {err_wlen, err_b_orphan, err_ovf, err_tmo, wr_outst};

    int total = 0;
    int bad   = 0;

    // Reference model: bursts as queue entries, completed-write counts per ID.
    int m_aw_id[$];
    int m_aw_len[$];
    int m_w_beats[$];
    int m_beats;
    int m_cnt[1 << ID_W];
    bit m_wlen, m_orph, m_ovf, m_tmo;
    int m_tmr;

    function automatic int m_outst();
        int s = 0;
        for (int i = 0; i < (1 << ID_W); i++) s += m_cnt[i];
        return s;
    endfunction

    function automatic logic [CW+3:0] exp_vec();
        return {m_wlen, m_orph, m_ovf, m_tmo, CW'(m_outst())};
    endfunction

    task automatic model_reset();
        m_aw_id.delete();
        m_aw_len.delete();
        m_w_beats.delete();
        m_beats = 0;
        for (int i = 0; i < (1 << ID_W); i++) m_cnt[i] = 0;
        m_wlen = 0; m_orph = 0; m_ovf = 0; m_tmo = 0;
        m_tmr = 0;
    endtask

    task automatic model_tick();
        bit aw_hs, w_hs, b_hs, pair, same;
        bit s_wlen, s_orph, s_ovf, s_tmo;
        int pid, plen, pbeats, outst_before;
        if (!areset_n) begin
            model_reset();
            return;
        end
        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
        b_hs  = bvalid && bready;
        s_wlen = 0; s_orph = 0; s_ovf = 0; s_tmo = 0;
        pid = 0; plen = 0; pbeats = 0;
        outst_before = m_outst() % (1 << CW);
        pair = (m_aw_id.size() > 0) && (m_w_beats.size() > 0);
        if (pair) begin
            pid    = m_aw_id.pop_front();
            plen   = m_aw_len.pop_front();
            pbeats = m_w_beats.pop_front();
            s_wlen = (pbeats != plen + 1);
        end
        if (aw_hs) begin
            if (m_aw_id.size() < DEPTH) begin
                m_aw_id.push_back(int'(awid));
                m_aw_len.push_back(int'(awlen));
            end else s_ovf = 1;
        end
        if (w_hs) begin
            m_beats++;
            if (wlast) begin
                if (m_w_beats.size() < DEPTH) m_w_beats.push_back(m_beats);
                else s_ovf = 1;
                m_beats = 0;
            end
        end
        same = pair && b_hs && (int'(bid) == pid);
        if (!same) begin
            if (pair) begin
                if (m_cnt[pid] == DEPTH) s_ovf = 1;
                else m_cnt[pid]++;
            end
            if (b_hs) begin
                if (m_cnt[int'(bid)] == 0) s_orph = 1;
                else m_cnt[int'(bid)]--;
            end
        end
`ifdef AXI4_WCHK_TMO_EN
        if (b_hs || outst_before == 0) m_tmr = 0;
        else if (m_tmr < TMO_CYC) m_tmr++;
        s_tmo = (m_tmr == TMO_CYC);
`endif
        m_wlen = s_wlen || (m_wlen && !err_clr);
        m_orph = s_orph || (m_orph && !err_clr);
        m_ovf  = s_ovf  || (m_ovf  && !err_clr);
        m_tmo  = s_tmo  || (m_tmo  && !err_clr);
    endtask

    // Inputs change at the falling edge; the model advances at the rising edge; checks follow at the next falling edge.
    task automatic step();
        @(posedge aclk);
        model_tick();
        @(negedge aclk);
    endtask

    task automatic idle_in();
        awvalid = 0; awready = 0; wvalid = 0; wready = 0; wlast = 0;
        bvalid = 0; bready = 0; err_clr = 0;
    endtask

    task automatic apply_reset();
        idle_in();
        areset_n = 0;
        model_reset();
        repeat (2) @(negedge aclk);
        areset_n = 1;
    endtask

    task automatic drive_aw(input int id, input int len);
        awvalid = 1; awready = 1; awid = ID_W'(id); awlen = 8'(len);
    endtask

    task automatic drive_w(input bit last);
        wvalid = 1; wready = 1; wlast = last;
    endtask

    task automatic drive_b(input int id);
        bvalid = 1; bready = 1; bid = ID_W'(id);
    endtask

    task automatic aw_beat(input int id, input int len);
        drive_aw(id, len); step(); idle_in();
    endtask

    task automatic w_beat(input bit last);
        drive_w(last); step(); idle_in();
    endtask

    task automatic b_beat(input int id);
        drive_b(id); step(); idle_in();
    endtask

    task automatic test_reset();
        apply_reset();
        step();
        total++;
        if (obs !== '0) begin
            bad++; $display("FAIL reset_state: got %h want %h", obs, '0);
        end
        total++;
        if (obs !== exp_vec()) begin
            bad++; $display("FAIL reset_model: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_basic_write();
        aw_beat(3, 3);
        total++;
        if (wr_outst !== CW'(0)) begin
            bad++; $display("FAIL basic_unpaired: got %0d want 0", wr_outst);
        end
        for (int i = 0; i < 4; i++) w_beat(i == 3);
        step();
        total++;
        if (obs !== {4'b0000, CW'(1)} || obs !== exp_vec()) begin
            bad++; $display("FAIL basic_paired: got %h want %h", obs, exp_vec());
        end
        b_beat(3);
        total++;
        if (obs !== '0) begin
            bad++; $display("FAIL basic_done: got %h want 0", obs);
        end
    endtask

    task automatic test_w_before_aw();
        w_beat(0); w_beat(1); w_beat(1);
        aw_beat(1, 1);
        aw_beat(2, 0);
        step(); step();
        total++;
        if (obs !== exp_vec() || wr_outst !== CW'(2)) begin
            bad++; $display("FAIL wfirst_paired: got %h want %h", obs, exp_vec());
        end
        b_beat(2);
        b_beat(1);
        total++;
        if (obs !== '0 || obs !== exp_vec()) begin
            bad++; $display("FAIL wfirst_ooo_b: got %h want 0", obs);
        end
    endtask

    task automatic test_wlen_err();
        aw_beat(0, 3);
        w_beat(0); w_beat(1);
        total++;
        if (err_wlen !== 1'b0) begin
            bad++; $display("FAIL wlen_early: got %b want 0", err_wlen);
        end
        step();
        total++;
        if (err_wlen !== 1'b1 || obs !== exp_vec()) begin
            bad++; $display("FAIL wlen_set: got %h want %h", obs, exp_vec());
        end
        b_beat(0);
        err_clr = 1; step(); idle_in();
        total++;
        if (err_wlen !== 1'b0 || obs !== exp_vec()) begin
            bad++; $display("FAIL wlen_clr: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_orphan_aw_ovf();
        b_beat(5);
        total++;
        if (err_b_orphan !== 1'b1 || err_ovf !== 1'b0) begin
            bad++; $display("FAIL orphan: got orph=%b ovf=%b want 1 0", err_b_orphan, err_ovf);
        end
        for (int i = 0; i < 8; i++) aw_beat(i, 0);
        total++;
        if (err_ovf !== 1'b0) begin
            bad++; $display("FAIL aw_full_no_ovf: got %b want 0", err_ovf);
        end
        aw_beat(8, 0);
        total++;
        if (err_ovf !== 1'b1 || obs !== exp_vec()) begin
            bad++; $display("FAIL aw_ovf: got %h want %h", obs, exp_vec());
        end
        apply_reset();
    endtask

    task automatic test_cnt_ovf();
        for (int i = 0; i < 9; i++) begin
            drive_aw(7, 0); drive_w(1); step(); idle_in();
        end
        total++;
        if (err_ovf !== 1'b0 || wr_outst !== CW'(8)) begin
            bad++; $display("FAIL cnt_at_depth: got %h want ovf=0 outst=8", obs);
        end
        step();
        total++;
        if (err_ovf !== 1'b1 || wr_outst !== CW'(8) || obs !== exp_vec()) begin
            bad++; $display("FAIL cnt_ovf: got %h want %h", obs, exp_vec());
        end
        for (int i = 0; i < 8; i++) b_beat(7);
        total++;
        if (obs !== exp_vec() || wr_outst !== CW'(0)) begin
            bad++; $display("FAIL cnt_drain: got %h want %h", obs, exp_vec());
        end
        apply_reset();
    endtask

    task automatic test_same_cycle();
        drive_aw(4, 0); drive_w(1); step(); idle_in();
        b_beat(4);
        total++;
        if (obs !== '0 || obs !== exp_vec()) begin
            bad++; $display("FAIL same_cycle_inc_dec: got %h want 0", obs);
        end
    endtask

    task automatic test_long_burst();
        aw_beat(2, 255);
        for (int i = 0; i < 256; i++) w_beat(i == 255);
        step();
        total++;
        if (err_wlen !== 1'b0 || wr_outst !== CW'(1)) begin
            bad++; $display("FAIL burst_256: got %h want wlen=0 outst=1", obs);
        end
        aw_beat(1, 255);
        for (int i = 0; i < 258; i++) w_beat(i == 257);
        step();
        total++;
        if (err_wlen !== 1'b1 || obs !== exp_vec()) begin
            bad++; $display("FAIL burst_258: got %h want %h", obs, exp_vec());
        end
        apply_reset();
    endtask

    task automatic test_reset_mid_burst();
        aw_beat(0, 3);
        w_beat(0); w_beat(0);
        areset_n = 0;
        model_reset();
        @(negedge aclk);
        areset_n = 1;
        drive_aw(0, 0); drive_w(1); step(); idle_in();
        step();
        total++;
        if (obs !== {4'b0000, CW'(1)}) begin
            bad++; $display("FAIL rst_mid_paired: got %h want 1", obs);
        end
        b_beat(0);
        total++;
        if (obs !== '0 || obs !== exp_vec()) begin
            bad++; $display("FAIL rst_mid_clean: got %h want 0", obs);
        end
    endtask

    task automatic test_timeout();
        bit seen = 0;
        drive_aw(6, 0); drive_w(1); step(); idle_in();
        for (int i = 0; i < TMO_CYC + 4; i++) begin
            step();
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL tmo_cycle%0d: got %h want %h", i, obs, exp_vec());
            end
            if (err_tmo === 1'b1) seen = 1;
        end
        total++;
`ifdef AXI4_WCHK_TMO_EN
        if (err_tmo !== 1'b1) begin
            bad++; $display("FAIL tmo_set: got %b want 1", err_tmo);
        end
`else
        if (seen || err_tmo !== 1'b0) begin
            bad++; $display("FAIL tmo_disabled: got %b want 0", err_tmo);
        end
`endif
        b_beat(6);
        apply_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            awvalid = ($urandom_range(0, 3) == 0);
            awready = ($urandom_range(0, 1) == 0);
            awid    = ID_W'($urandom_range(0, 3));
            awlen   = 8'($urandom_range(0, 3));
            wvalid  = ($urandom_range(0, 1) == 0);
            wready  = ($urandom_range(0, 3) != 0);
            wlast   = ($urandom_range(0, 2) == 0);
            bvalid  = ($urandom_range(0, 3) == 0);
            bready  = ($urandom_range(0, 1) == 0);
            bid     = ID_W'($urandom_range(0, 3));
            err_clr = ($urandom_range(0, 31) == 0);
            step();
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL random_cycle%0d: got %h want %h", i, obs, exp_vec());
            end
        end
        idle_in();
    endtask

    initial begin
        @(negedge aclk);
        test_reset();
        test_basic_write();
        test_w_before_aw();
        test_wlen_err();
        test_orphan_aw_ovf();
        test_cnt_ovf();
        test_same_cycle();
        test_long_burst();
        test_reset_mid_burst();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
